inc_share_sched: RTL

//  Time-multiplexes one shared 24-bit incrementer (inc1) across NUM_REQ event counters.

---
 rtl/inc_share_sched_pkg.sv | 15 +
 rtl/inc_share_sched_if.sv | 27 ++
 rtl/inc_share_sched_inc1.sv | 11 +
 rtl/inc_share_sched_rr_arbiter.sv | 29 ++
 rtl/inc_share_sched.sv | 92 +++++++++
 5 files changed

// File: rtl/inc_share_sched_pkg.sv
// rtl/inc_share_sched_pkg.sv - shared types for the incrementer scheduler
// Counter width, counter type and the pipeline stage-entry record.
package inc_share_pkg;
   localparam int CNT_W     = 24;
   localparam int IDX_MAX_W = 4;

   typedef logic [CNT_W-1:0]     cnt_t;
   typedef logic [IDX_MAX_W-1:0] idx_t;

   typedef struct packed {
      logic valid;
      idx_t idx;
      cnt_t op;
   } stage_t;
endpackage

// File: rtl/inc_share_sched_if.sv
// rtl/inc_share_sched_if.sv - request, load and counter-bank bundle
// The master side posts requests and loads; the slave side owns the counters.
interface inc_share_sched_if
   import inc_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       clr;
   logic                     ld_valid;
   logic [IDX_W-1:0]         ld_idx;
   cnt_t                     ld_data;
   logic [NUM_REQ*CNT_W-1:0] cnt;
   logic [NUM_REQ-1:0]       wrap;

   modport master (
      output req_valid, clr, ld_valid, ld_idx, ld_data,
      input  req_ready, cnt, wrap
   );

   modport slave (
      input  req_valid, clr, ld_valid, ld_idx, ld_data,
      output req_ready, cnt, wrap
   );
endinterface

// File: rtl/inc_share_sched_inc1.sv
// rtl/inc_share_sched_inc1.sv - the single shared 24-bit incrementer
// Carry-in is fixed at one; carry-out flags the 0xFFFFFF -> 0 wrap.
module inc1
   import inc_share_pkg::*;
(
   input  cnt_t i_a,
   output cnt_t o_sum,
   output logic o_cout
);
   assign {o_cout, o_sum} = {1'b0, i_a} + {{CNT_W{1'b0}}, 1'b1};
endmodule

// File: rtl/inc_share_sched_rr_arbiter.sv
// rtl/inc_share_sched_rr_arbiter.sv - combinational round-robin grant
// Searches upward from i_ptr (wrapping) and grants the first asserted request.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx
);
   logic w_found;
   int   w_c;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_c     = 0;
      for (int k = 0; k < N; k++) begin
         w_c = (int'(i_ptr) + k) % N;
         if (!w_found && i_req[w_c]) begin
            w_found    = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_idx      = IDX_W'(w_c);
         end
      end
   end
endmodule

// File: rtl/inc_share_sched.sv
// rtl/inc_share_sched.sv - round-robin sharing of one incrementer across counters
// Grant -> operand capture (r_s1) -> inc1 + writeback into the counter bank.
module inc_share_sched
   import inc_share_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   inc_share_sched_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   cnt_t               r_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] r_wrap;
   logic [IDX_W-1:0]   r_ptr;
   stage_t             r_s1;

   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_gnt;
   logic [NUM_REQ-1:0] w_wb;
   logic [IDX_W-1:0]   w_gidx;
   logic               w_xfer;
   cnt_t               w_inc;
   cnt_t               w_op;
   logic               w_cout;

   // A channel being cleared or loaded this cycle must not be granted, so a
   // fresh capture can never collide with an override of the same counter.
   always_comb begin
      w_elig = '0;
      w_wb   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = bus.req_valid[i] & ~bus.clr[i] & ~i_rst
                   & ~(bus.ld_valid & (bus.ld_idx == IDX_W'(i)));
         w_wb[i]   = r_s1.valid & (r_s1.idx == idx_t'(i));
      end
   end

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .i_req (w_elig),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gidx)
   );

   assign w_xfer        = |w_gnt;
   assign bus.req_ready = w_gnt;

   inc1 u_inc1 (
      .i_a    (r_s1.op),
      .o_sum  (w_inc),
      .o_cout (w_cout)
   );

   // Back-to-back hits on one channel take the value being written this edge.
   assign w_op = (r_s1.valid && (r_s1.idx == idx_t'(w_gidx))) ? w_inc : r_cnt[w_gidx];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_cnt[i] <= '0;
         end
         r_wrap <= '0;
         r_ptr  <= '0;
         r_s1   <= '0;
      end else begin
         r_wrap <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.clr[i]) begin
               r_cnt[i] <= '0;
            end else if (bus.ld_valid && (bus.ld_idx == IDX_W'(i))) begin
               r_cnt[i] <= bus.ld_data;
            end else if (w_wb[i]) begin
               r_cnt[i]  <= w_inc;
               r_wrap[i] <= w_cout;
            end
         end
         r_s1.valid <= w_xfer;
         r_s1.idx   <= idx_t'(w_gidx);
         r_s1.op    <= w_op;
         if (w_xfer) begin
            r_ptr <= (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
      assign bus.cnt[g*CNT_W +: CNT_W] = r_cnt[g];
   end
   assign bus.wrap = r_wrap;
endmodule
